smi_mem_port_arbiter_x2: RTL
============================

Name: smi_mem_port_arbiter_x2

Overview:
- Shares one SMI memory port (the combined read/write SMI bus adaptor port) between two upstream SMI clients, A and B.
- Request frames are arbitrated round-robin and forwarded whole; a frame is never interleaved with another.
- On each request header the arbiter stamps the granting client's index into a reserved tag bit.
- Response frames are steered back to the owning client by that bit, which is cleared before delivery. Out-of-order responses from the AXI side are handled correctly.

Parameters:
- FlitWidth, 16, flit width in bytes; data buses are FlitWidth*8 bits; minimum 16.
- TagBit, 15, bit index in header flit data carrying the client index; must lie in header byte 1 (8..15).

Ports:
- clk  input  1  clock
- srst  input  1  reset, asynchronous, active-high
- reqAReady / reqBReady  input  1  client A/B request flit valid
- reqAEofc / reqBEofc  input  8  0 = mid-frame; 1..FlitWidth = last flit, valid byte count
- reqAData / reqBData  input  FlitWidth*8  request flit data
- reqAStop / reqBStop  output  1  backpressure to client A/B
- respAReady / respBReady  output  1  response flit valid to A/B
- respAEofc / respBEofc  output  8  response end-of-frame count
- respAData / respBData  output  FlitWidth*8  response data
- respAStop / respBStop  input  1  client backpressure
- busReqReady  output  1  shared request flit valid
- busReqEofc  output  8  shared request eofc
- busReqData  output  FlitWidth*8  shared request data
- busReqStop  input  1  adaptor backpressure
- busRespReady  input  1  shared response valid
- busRespEofc  input  8  shared response eofc
- busRespData  input  FlitWidth*8  shared response data
- busRespStop  output  1  backpressure to adaptor

Behaviour:
- Handshake (all SMI links): a flit transfers on a rising clk edge with Ready=1 and Stop=0. Ready/Eofc/Data are held stable while Stop=1. A frame ends on the flit with Eofc!=0.
- Reset (async assert): bus and response Ready outputs = 0. Eofc/Data outputs = 0. All Stop outputs = 1. Request FSM = IDLE, last-grant = B (A wins first), response FSM = RIDLE. Reset mid-frame discards partial frames without recovery.
- Request FSM states: IDLE, FWD_A, FWD_B.
  - IDLE: if only one client is Ready, grant it. If both are Ready, grant the client other than last-grant. Go to FWD_x; last-grant is updated at grant.
  - Grant cycle is a decision-only bubble: the next-cycle Stop is lowered for the granted client only. A non-granted client always sees Stop=1.
  - FWD_x: flits pass through a one-entry registered output stage (latency 1 cycle, client to busReq).
  - The first flit of each frame has bit TagBit set to 0 for A and 1 for B; all other bits pass unchanged.
  - reqxStop = outputRegFull && busReqStop.
  - On transfer of a flit with Eofc!=0, return to IDLE. The output register still drains while the next grant is decided.
  - A client's frame is held to completion regardless of the other client's Ready.
- Response FSM states: RIDLE, RET_A, RET_B.
  - RIDLE: on a bus response header flit, route by busRespData[TagBit] (0 = A, 1 = B) and clear that bit.
  - Subsequent flits route to the same client until Eofc!=0 transfers, then RIDLE.
  - Registered one-entry output per client, latency 1 cycle.
  - busRespStop = selected client's register full && respxStop. In RIDLE, busRespStop = 0 when both registers can accept.
- Simultaneous events:
  - A request header and a response header in the same cycle are independent; no interaction.
  - A request EOF and the new grant decision in the same cycle: the decision applies next cycle, guaranteeing one bubble.
- Client contract: the TagBit of request headers is driven 0 by clients. The arbiter overwrites it regardless.
- Throughput: one flit per cycle sustained within a frame; one-cycle idle between frames.

Test Plan:
- Only A sends a 3-flit write frame (Eofc 0,0,16), header bit15=1 -> busReq shows 3 flits, header bit15=0, 1 cycle latency, reqBStop=1 throughout.
- A and B both Ready after reset -> A frame forwarded fully, one bubble, then B frame with bit15=1; repeat -> strict A,B alternation.
- busReqStop held 1 for 5 cycles mid-frame -> no flit lost or duplicated; reqAStop=1 while the register is full; data order preserved.
- Response header bit15=1, 2 flits -> delivered on respB with bit15=0; respAReady stays 0.
- Interleaved responses B-frame then A-frame back to back, respBStop=1 for 3 cycles -> busRespStop=1 those cycles; A frame is delivered only after B completes.
- srst asserted mid-request-frame -> outputs reach reset values immediately (async). After release, a new frame from B is granted first only if A is idle, and is forwarded cleanly.

Source files
------------

// File: rtl/smi_mem_port_arbiter_x2.sv
// Purpose : shares one SMI memory port between two SMI clients (A, B); whole request
//           frames are granted round-robin and tagged with the client index, and
//           responses are steered back to their owner by that tag.
// Latency : 1 cycle client->busReq (plus a 1-cycle grant bubble per frame);
//           1 cycle busResp->respA/respB.
// Backpressure: reqxStop = output register full && busReqStop for the granted client,
//           1 otherwise; busRespStop = destination register full && its respxStop.
//
// Ports:
//   clk, srst          clock, asynchronous active-high reset
//   reqA*/reqB*        upstream request links (Ready/Eofc/Data in, Stop out)
//   respA*/respB*      upstream response links (Ready/Eofc/Data out, Stop in)
//   busReq*            shared request link toward the adaptor
//   busResp*           shared response link from the adaptor
//
// FlitWidth must be >= 16 and TagBit must lie in header byte 1 (8..15).
module smi_mem_port_arbiter_x2 #(
    parameter int FlitWidth = 16,
    parameter int TagBit    = 15
) (
    input  logic                   clk,
    input  logic                   srst,

    input  logic                   reqAReady,
    input  logic [7:0]             reqAEofc,
    input  logic [FlitWidth*8-1:0] reqAData,
    output logic                   reqAStop,

    input  logic                   reqBReady,
    input  logic [7:0]             reqBEofc,
    input  logic [FlitWidth*8-1:0] reqBData,
    output logic                   reqBStop,

    output logic                   respAReady,
    output logic [7:0]             respAEofc,
    output logic [FlitWidth*8-1:0] respAData,
    input  logic                   respAStop,

    output logic                   respBReady,
    output logic [7:0]             respBEofc,
    output logic [FlitWidth*8-1:0] respBData,
    input  logic                   respBStop,

    output logic                   busReqReady,
    output logic [7:0]             busReqEofc,
    output logic [FlitWidth*8-1:0] busReqData,
    input  logic                   busReqStop,

    input  logic                   busRespReady,
    input  logic [7:0]             busRespEofc,
    input  logic [FlitWidth*8-1:0] busRespData,
    output logic                   busRespStop
);

    localparam int DataWidth = FlitWidth * 8;

    typedef struct packed {
        logic [7:0]           eofc;
        logic [DataWidth-1:0] data;
    } flit_t;

    // ------------------------------------------------------------------
    // Request path: round-robin frame arbiter feeding one output register
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FWD_A = 2'd1,
        FWD_B = 2'd2
    } reqState_t;

    reqState_t reqState;
    reqState_t reqStateNext;
    logic      lastGrantB;      // 1 = B was granted last, so A wins a tie
    logic      lastGrantBNext;
    logic      firstFlit;       // next flit from the granted client is its header
    logic      firstFlitNext;

    flit_t     busOut;
    logic      busOutFull;

    logic      srcReady;
    flit_t     srcFlit;
    logic      srcStop;
    logic      srcXfer;

    always_comb begin
        reqStateNext   = reqState;
        lastGrantBNext = lastGrantB;
        firstFlitNext  = firstFlit;
        reqAStop       = 1'b1;
        reqBStop       = 1'b1;
        srcReady       = 1'b0;
        srcFlit        = '0;
        // The register can take a new flit whenever it is empty or draining.
        srcStop        = busOutFull && busReqStop;

        case (reqState)
            IDLE: begin
                // Decision-only cycle: both clients keep Stop high here, which
                // is what produces the single bubble between frames.
                if (reqAReady && (!reqBReady || lastGrantB)) begin
                    reqStateNext   = FWD_A;
                    lastGrantBNext = 1'b0;
                    firstFlitNext  = 1'b1;
                end else if (reqBReady) begin
                    reqStateNext   = FWD_B;
                    lastGrantBNext = 1'b1;
                    firstFlitNext  = 1'b1;
                end
            end
            FWD_A: begin
                reqAStop = srcStop;
                srcReady = reqAReady;
                srcFlit  = '{eofc: reqAEofc, data: reqAData};
            end
            FWD_B: begin
                reqBStop = srcStop;
                srcReady = reqBReady;
                srcFlit  = '{eofc: reqBEofc, data: reqBData};
            end
            default: begin
                reqStateNext = IDLE;
            end
        endcase

        // Stamp the owner index into the header; the value clients put there
        // is ignored.
        if (firstFlit) begin
            srcFlit.data[TagBit] = (reqState == FWD_B);
        end

        srcXfer = srcReady && !srcStop;
        if (srcXfer) begin
            firstFlitNext = 1'b0;
            if (srcFlit.eofc != 8'd0) begin
                reqStateNext = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            reqState   <= IDLE;
            lastGrantB <= 1'b1;
            firstFlit  <= 1'b0;
            busOutFull <= 1'b0;
            busOut     <= '0;
        end else begin
            reqState   <= reqStateNext;
            lastGrantB <= lastGrantBNext;
            firstFlit  <= firstFlitNext;
            if (srcXfer) begin
                busOutFull <= 1'b1;
                busOut     <= srcFlit;
            end else if (!busReqStop) begin
                busOutFull <= 1'b0;
            end
        end
    end

    assign busReqReady = busOutFull;
    assign busReqEofc  = busOut.eofc;
    assign busReqData  = busOut.data;

    // ------------------------------------------------------------------
    // Response path: tag-steered demux into one register per client
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        RIDLE = 2'd0,
        RET_A = 2'd1,
        RET_B = 2'd2
    } respState_t;

    respState_t respState;
    respState_t respStateNext;

    // Holds busRespStop high through reset and the first cycle after it.
    logic  respArmed;

    flit_t respAOut;
    flit_t respBOut;
    logic  respAFull;
    logic  respBFull;

    logic  canA;
    logic  canB;
    logic  routeB;
    flit_t inFlit;
    logic  respXfer;
    logic  loadA;
    logic  loadB;

    assign canA = !respAFull || !respAStop;
    assign canB = !respBFull || !respBStop;

    always_comb begin
        respStateNext = respState;
        routeB        = 1'b0;
        inFlit        = '{eofc: busRespEofc, data: busRespData};
        busRespStop   = 1'b1;

        case (respState)
            RIDLE: begin
                // Destination is not known until the header is seen, so only
                // accept while both client registers have room.
                routeB               = busRespData[TagBit];
                inFlit.data[TagBit]  = 1'b0;
                busRespStop          = !(canA && canB);
            end
            RET_A: begin
                routeB      = 1'b0;
                busRespStop = !canA;
            end
            RET_B: begin
                routeB      = 1'b1;
                busRespStop = !canB;
            end
            default: begin
                respStateNext = RIDLE;
            end
        endcase

        if (!respArmed) begin
            busRespStop = 1'b1;
        end

        respXfer = busRespReady && !busRespStop;
        if (respXfer) begin
            if (busRespEofc != 8'd0) begin
                respStateNext = RIDLE;
            end else begin
                respStateNext = routeB ? RET_B : RET_A;
            end
        end

        loadA = respXfer && !routeB;
        loadB = respXfer && routeB;
    end

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            respState <= RIDLE;
            respArmed <= 1'b0;
            respAFull <= 1'b0;
            respBFull <= 1'b0;
            respAOut  <= '0;
            respBOut  <= '0;
        end else begin
            respState <= respStateNext;
            respArmed <= 1'b1;

            if (loadA) begin
                respAFull <= 1'b1;
                respAOut  <= inFlit;
            end else if (!respAStop) begin
                respAFull <= 1'b0;
            end

            if (loadB) begin
                respBFull <= 1'b1;
                respBOut  <= inFlit;
            end else if (!respBStop) begin
                respBFull <= 1'b0;
            end
        end
    end

    assign respAReady = respAFull;
    assign respAEofc  = respAOut.eofc;
    assign respAData  = respAOut.data;
    assign respBReady = respBFull;
    assign respBEofc  = respBOut.eofc;
    assign respBData  = respBOut.data;

endmodule
